// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: unified instruction/data memory handshake
//   mem_req      controller -> memory  request valid
//   mem_we       controller -> memory  request is a store
//   mem_addr_sel controller -> memory  address mux select (0=PC, 1=ALU result)
//   mem_rdata    memory -> controller  read data
//   mem_ready    memory -> controller  pending request completes this cycle
interface multicycle_controller_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  modport master (output mem_req, mem_we, mem_addr_sel, input mem_rdata, mem_ready);
  modport slave (input mem_req, mem_we, mem_addr_sel, output mem_rdata, mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle sequencer driving datapath selects and strobes
//   clk, rst_n       clock, asynchronous active-low reset
//   mem              memory handshake (master side)
//   i_branch_taken   ALU compare result for the current branch
//   o_instr          instruction register
//   o_pc_we/o_pc_src PC update strobe and source (0=PC+4, 1=PC+imm, 2=ALU&~1)
//   o_alu_a_sel      0=rs1, 1=PC
//   o_alu_b_sel      0=rs2, 1=immediate
//   o_alu_op_sel     0=add, 1=funct decode, 2=branch compare
//   o_rf_we/o_wb_sel register write strobe and source (0=ALU,1=load,2=PC+4,3=imm)
//   o_state          current state (debug)
//   o_halted         sticky: ECALL/EBREAK retired
//   o_illegal        sticky: unsupported opcode decoded
module multicycle_controller #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        mem,
  input  logic                           i_branch_taken,
  output logic [31:0]                    o_instr,
  output logic                           o_pc_we,
  output logic [1:0]                     o_pc_src,
  output logic                           o_alu_a_sel,
  output logic                           o_alu_b_sel,
  output logic [1:0]                     o_alu_op_sel,
  output logic                           o_rf_we,
  output logic [1:0]                     o_wb_sel,
  output logic [2:0]                     o_state,
  output logic                           o_halted,
  output logic                           o_illegal
);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;
  state_t      r_state;
  logic [31:0] r_instr;
  logic        r_halted;
  logic        r_illegal;
  logic [6:0]  w_opc;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store;
  logic        w_opimm, w_op, w_fence, w_system, w_legal, w_sel_act;
  assign w_opc     = r_instr[6:0];
  assign w_lui     = w_opc == 7'b0110111;
  assign w_auipc   = w_opc == 7'b0010111;
  assign w_jal     = w_opc == 7'b1101111;
  assign w_jalr    = w_opc == 7'b1100111;
  assign w_branch  = w_opc == 7'b1100011;
  assign w_load    = w_opc == 7'b0000011;
  assign w_store   = w_opc == 7'b0100011;
  assign w_opimm   = w_opc == 7'b0010011;
  assign w_op      = w_opc == 7'b0110011;
  assign w_fence   = w_opc == 7'b0001111;
  assign w_system  = w_opc == 7'b1110011;
  assign w_legal   = w_lui | w_auipc | w_jal | w_jalr | w_branch | w_load | w_store |
                     w_opimm | w_op | w_fence | w_system;
  // ALU selects are live in EXECUTE and held through MEMORY for the address
  assign w_sel_act = (r_state == EXECUTE) || (r_state == MEMORY);
  // strobes are gated by rst_n so they drop the moment reset asserts
  always_comb begin
    mem.mem_req      = rst_n && (r_state == FETCH || r_state == MEMORY);
    mem.mem_we       = rst_n && r_state == MEMORY && w_store;
    mem.mem_addr_sel = r_state == MEMORY;
    o_alu_a_sel      = w_sel_act && w_auipc;
    o_alu_b_sel      = w_sel_act && (w_opimm || w_load || w_store || w_jalr || w_auipc);
    o_alu_op_sel     = !w_sel_act ? 2'd0 : (w_op || w_opimm) ? 2'd1 : w_branch ? 2'd2 : 2'd0;
    o_pc_we          = rst_n && ((r_state == EXECUTE && w_branch) ||
                                 (r_state == MEMORY && w_store && mem.mem_ready) ||
                                 r_state == WRITEBACK);
    o_pc_src         = (r_state == EXECUTE) ? (w_branch && i_branch_taken ? 2'd1 : 2'd0) :
                       (r_state == WRITEBACK) ? (w_jal ? 2'd1 : w_jalr ? 2'd2 : 2'd0) : 2'd0;
    o_rf_we          = rst_n && r_state == WRITEBACK && !w_fence;
    o_wb_sel         = w_load ? 2'd1 : (w_jal || w_jalr) ? 2'd2 : w_lui ? 2'd3 : 2'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_instr   <= NOP_INSTR;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH: if (mem.mem_ready) begin
          r_instr <= mem.mem_rdata;
          r_state <= DECODE;
        end
        DECODE: if (!w_legal) begin
          r_state   <= HALT;
          r_illegal <= 1'b1;
        end else if (w_system) begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end else r_state <= EXECUTE;
        EXECUTE:   r_state <= w_branch ? FETCH : (w_load || w_store) ? MEMORY : WRITEBACK;
        MEMORY:    if (mem.mem_ready) r_state <= w_load ? WRITEBACK : FETCH;
        WRITEBACK: r_state <= FETCH;
        default:   r_state <= HALT;
      endcase
    end
  end
  assign o_instr   = r_instr;
  assign o_state   = r_state;
  assign o_halted  = r_halted;
  assign o_illegal = r_illegal;
endmodule
